// File: rtl/swipt_ask_tx_pkg.sv
// Shared SWIPT definitions for the ASK byte transmitter.
// Contents:
//   swipt_state_e - transmitter FSM states
//   DUTY_HI_DEF   - default duty word for a mark bit and for idle
//   DUTY_LO_DEF   - default duty word for a space bit
//   FRAME_BITS    - bits per frame: start, 8 data, parity, stop
package swipt_ask_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } swipt_state_e;

  localparam logic [11:0] DUTY_HI_DEF = 12'h0FA;
  localparam logic [11:0] DUTY_LO_DEF = 12'h07D;
  localparam int          FRAME_BITS  = 11;

endpackage

// File: rtl/swipt_bit_timer.sv
// Bit-period timer for the SWIPT ASK transmitter.
// A 16-bit down-counter. It is reloaded to BIT_CLKS-1 at the start of each
// bit and stops at zero. The terminal count therefore marks the last cycle
// of a bit.
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset; clears the counter
//   clr_i   - synchronous clear to zero, used when a frame is abandoned
//   load_i  - reload to BIT_CLKS-1; this starts a new bit period
//   tc_o    - high while the counter is zero
module swipt_bit_timer #(
  parameter int BIT_CLKS = 2500
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic load_i,
  output logic tc_o
);

  localparam logic [15:0] RELOAD = 16'(BIT_CLKS - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Clear has priority over load. The counter holds at zero between frames.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = RELOAD;
    end else if (count_q != '0) begin
      count_d = count_q - 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/swipt_ask_tx.sv
// SWIPT ASK byte transmitter.
// The block sends one byte as an 11-bit frame: start 0, data LSB first,
// even parity, stop 1. It keys the carrier amplitude by choosing the duty
// word on output l. Each bit lasts BIT_CLKS clocks. If the link-alive
// qualifier drops, the frame is abandoned and tx_abort pulses.
// Ports:
//   clk, nrst   - clock, asynchronous active-low reset
//   swiptAlive  - link-alive qualifier; needed to accept and to keep sending
//   tx_data     - byte to send; tx_valid marks it valid
//   tx_ready    - a byte is accepted this cycle if tx_valid is also high
//   l           - registered duty word to the SwiptOut driver
//   tx_busy     - a frame is in progress
//   tx_done     - one-cycle pulse in the first idle cycle after a frame
//   tx_abort    - one-cycle pulse after a frame is abandoned
module swipt_ask_tx
  import swipt_ask_tx_pkg::*;
#(
  parameter int          BIT_CLKS = 2500,
  parameter logic [11:0] DUTY_HI  = DUTY_HI_DEF,
  parameter logic [11:0] DUTY_LO  = DUTY_LO_DEF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptAlive,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [11:0] l,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_abort
);

  localparam int DATA_BITS = FRAME_BITS - 3;

  swipt_state_e state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [7:0]   data_q, data_d;
  logic [11:0]  l_q, l_d;
  logic         done_q, done_d;
  logic         abort_q, abort_d;
  logic         timerLoad;
  logic         timerClr;
  logic         bitEnd;
  logic [2:0]   nextIdx;

  function automatic logic [11:0] dutyOf(input logic b);
    return b ? DUTY_HI : DUTY_LO;
  endfunction

  swipt_bit_timer #(
    .BIT_CLKS(BIT_CLKS)
  ) u_timer (
    .clk_i (clk),
    .rst_ni(nrst),
    .clr_i (timerClr),
    .load_i(timerLoad),
    .tc_o  (bitEnd)
  );

  // tx_ready also depends on nrst, so it is low for the whole reset.
  assign tx_ready = (state_q == IDLE) && swiptAlive && nrst;
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = done_q;
  assign tx_abort = abort_q;
  assign l        = l_q;
  assign nextIdx  = idx_q + 3'd1;

  // The next-state logic computes the duty word for the bit that starts at
  // this edge. The registered l therefore changes together with the state
  // or the bit index. A lost link overrides every other transition.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    l_d       = l_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    timerLoad = 1'b0;
    timerClr  = 1'b0;
    if ((state_q != IDLE) && !swiptAlive) begin
      state_d  = IDLE;
      idx_d    = '0;
      l_d      = DUTY_HI;
      abort_d  = 1'b1;
      timerClr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          l_d = DUTY_HI;
          if (tx_valid && tx_ready) begin
            data_d    = tx_data;
            idx_d     = '0;
            state_d   = START;
            l_d       = DUTY_LO;
            timerLoad = 1'b1;
          end
        end
        START: begin
          if (bitEnd) begin
            state_d   = DATA;
            idx_d     = '0;
            l_d       = dutyOf(data_q[0]);
            timerLoad = 1'b1;
          end
        end
        DATA: begin
          if (bitEnd) begin
            idx_d     = nextIdx;
            timerLoad = 1'b1;
            if (idx_q == 3'(DATA_BITS - 1)) begin
              state_d = PARITY;
              l_d     = dutyOf(^data_q);
            end else begin
              l_d = dutyOf(data_q[nextIdx]);
            end
          end
        end
        PARITY: begin
          if (bitEnd) begin
            state_d   = STOP;
            l_d       = DUTY_HI;
            timerLoad = 1'b1;
          end
        end
        STOP: begin
          if (bitEnd) begin
            state_d = IDLE;
            l_d     = DUTY_HI;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          l_d     = DUTY_HI;
        end
      endcase
    end
  end

  // Reset discards any frame in progress without an abort pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      l_q     <= DUTY_HI;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      l_q     <= l_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: doc/swipt_ask_tx.md
SWIPT_ASK_TX -- requirements
Module: swipt_ask_tx

Interface
REQ-001 Parameter BIT_CLKS, default 2500: clk cycles per transmitted bit (one 40 kHz carrier period at 100 MHz clk); legal range 2..65535.
REQ-002 Parameter DUTY_HI, default 12'h0FA: duty word for mark (1) and idle.
REQ-003 Parameter DUTY_LO, default 12'h07D: duty word for space (0).
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 nrst  input  1  reset, asynchronous assert, active-low.
REQ-006 swiptAlive  input  1  link-alive qualifier from the heartbeat block.
REQ-007 tx_data  input  8  byte to send.
REQ-008 tx_valid  input  1  tx_data is valid.
REQ-009 tx_ready  output  1  block accepts a byte this cycle.
REQ-010 l  output  12  duty word to the SwiptOut driver; amplitude-shift-keys the carrier.
REQ-011 tx_busy  output  1  frame in progress.
REQ-012 tx_done  output  1  one-cycle pulse on frame completion.
REQ-013 tx_abort  output  1  one-cycle pulse on frame abort.

Function
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-015 tx_ready SHALL be 1 only when state = IDLE, swiptAlive = 1 and nrst = 1.
REQ-016 A byte SHALL be accepted on a rising clk edge with tx_valid & tx_ready; tx_data SHALL be latched at that edge and the FSM SHALL enter START.
REQ-017 tx_valid while tx_ready = 0 SHALL be ignored; no input buffering.
REQ-018 Frame SHALL be: start bit 0, data bits 0..7 (LSB first), even-parity bit (XOR of the 8 data bits), stop bit 1; 11 bits total.
REQ-019 Each bit SHALL hold l for exactly BIT_CLKS cycles, counted by a 16-bit down-counter reloaded to BIT_CLKS-1 at each bit start; frame length = 11*BIT_CLKS cycles.
REQ-020 l SHALL be DUTY_HI for bit value 1 and in IDLE, and DUTY_LO for bit value 0. l SHALL be registered and change on the same edge as the state or bit index.
REQ-021 DATA SHALL use a 3-bit bit index, 0..7; leaving DATA SHALL occur when the index wraps from 7 and the counter reaches 0.
REQ-022 tx_busy SHALL be 1 in every state except IDLE.
REQ-023 At the end of STOP the FSM SHALL return to IDLE and assert tx_done for that first IDLE cycle; tx_ready SHALL be 1 in the same cycle if swiptAlive = 1.
REQ-024 A back-to-back byte accepted in the tx_done cycle SHALL start START on the next cycle. Inter-frame idle SHALL be at least 1 cycle.
REQ-025 If swiptAlive = 0 in any non-IDLE state, the FSM SHALL go to IDLE on the next edge, set l = DUTY_HI and pulse tx_abort for one cycle; tx_done SHALL NOT pulse.
REQ-026 If swiptAlive falls on the same edge as a tx_valid & tx_ready transfer, the transfer SHALL complete and the abort SHALL follow on the next edge.

Reset
REQ-027 While nrst = 0: state = IDLE, l = DUTY_HI, tx_ready = 0, tx_busy = 0, tx_done = 0, tx_abort = 0, counters = 0, data register = 0.
REQ-028 Reset asserted mid-frame SHALL discard the frame immediately, with no tx_abort pulse.
REQ-029 After nrst rises, the first accept SHALL be possible on the first edge with swiptAlive = 1 and tx_valid = 1.

Structure
REQ-030 A shared SWIPT package SHALL hold the state enumeration, the default duty words (12'h0FA, 12'h07D) and the frame length constant 11.
REQ-031 One sub-module, swipt_bit_timer, SHALL implement the BIT_CLKS down-counter with load and a terminal-count output; the FSM and shift logic SHALL stay in swipt_ask_tx.

Verification (BIT_CLKS = 4, 100 MHz clk)
REQ-032 Reset release, swiptAlive = 1, no tx_valid -> tx_ready = 1, l = 12'h0FA, tx_busy = 0, and no tx_done or tx_abort pulses.
REQ-033 Send 0xA5 -> l per 4-cycle bit: LO, then H L H L L H L H, parity LO, stop HI; tx_done exactly 44 cycles after accept.
REQ-034 Send 0x01, then 0xFF with tx_valid held -> second accept in the tx_done cycle; parity bits HI then LO; 89 cycles from first accept to second tx_done.
REQ-035 Drop swiptAlive in DATA bit 3 of 0x3C -> next edge: l = 12'h0FA, tx_abort pulses once, tx_busy = 0, tx_done stays 0.
REQ-036 Assert nrst = 0 mid-frame -> outputs take reset values asynchronously; after release, 0x00 transmits as 10 LO bits then a HI stop bit.
REQ-037 tx_valid held while tx_busy = 1 -> that tx_data is not sampled; only the byte present in the tx_done cycle is sent next.
